regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the five-stage pipeline: two combinational read ports for decode, one pipeline write port from writeback, and one software port for host read/write of any register. After every reset a zeroing sweep clears the array and holds `ready` low. An optional bypass forwards same-cycle write data to the read ports. Register 0 always reads as zero.

## Interface
- `DATA_W`, 64: register width in bits
- `ADDR_W`, 5: address width; `NREGS = 2**ADDR_W` entries
- `BYPASS`, 1: 1 = read ports forward same-cycle write data; 0 = reads return array contents
- `clk` in 1: clock; all state updates on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `ready` out 1: high once the zeroing sweep has finished
- `r0addr` in ADDR_W: read port 0 address
- `r0data` out DATA_W: read port 0 data (combinational)
- `r1addr` in ADDR_W: read port 1 address
- `r1data` out DATA_W: read port 1 data (combinational)
- `waddr` in ADDR_W: pipeline write address
- `wdata` in DATA_W: pipeline write data
- `wena` in 1: pipeline write enable
- `swaddr` in ADDR_W: software port address
- `swdata` in DATA_W: software write data
- `swena` in 1: software write enable
- `swrd` in 1: software read request
- `swrdata` out DATA_W: registered software read data
- `swrvalid` out 1: one-cycle pulse when `swrdata` is valid

## Operation
- FSM has two states, INIT and RUN.
  - INIT: entered asynchronously whenever `rst_n` is low. The sweep counter starts at 0 while reset is held.
  - From the first edge after reset release, each edge writes 0 to `DFF[cnt]` and increments `cnt`.
  - After the edge that writes entry NREGS-1, the FSM moves to RUN.
- While in INIT:
  - `wena`, `swena` and `swrd` are ignored.
  - `r0data` and `r1data` read 0.
- In RUN:
  - `wena` writes `wdata` to `DFF[waddr]`.
  - `swena` writes `swdata` to `DFF[swaddr]`.
  - If both writes target the same address in the same cycle, the software write wins.
  - If they target different addresses, both writes complete.
  - Any write to address 0 is discarded; entry 0 stays 0.
- Reads:
  - `rNdata = DFF[rNaddr]`.
  - When `rNaddr == 0`, `rNdata` is 0.
  - When `BYPASS=1` and the address is non-zero and matches an active write in the same cycle, `rNdata` returns the write data. Priority for the forwarded value: `swdata` over `wdata`.
- Software read:
  - `swrd` sampled high in RUN captures `DFF[swaddr]` into `swrdata` and pulses `swrvalid` on the next cycle.
  - If `swena` and `swrd` are both high in the same cycle, the read returns the old contents (read-before-write), regardless of `BYPASS`.

## Timing
- Reset values:
  - `ready` = 0
  - `swrvalid` = 0
  - `swrdata` = 0
  - internal state: state = INIT, `cnt` = 0
  - array contents: undefined until the sweep overwrites them
- `ready` rises NREGS edges after `rst_n` deasserts: after 32 edges with the default `ADDR_W`. Writes are accepted from the following cycle.
- `rst_n` asserted mid-sweep or mid-RUN:
  - `ready` and `swrvalid` drop immediately.
  - The sweep restarts from entry 0.
  - A write on an edge coincident with reset assertion is lost.
- Write latency is 1 cycle. With `BYPASS=0`, data is visible on the read ports the cycle after the write edge.
- `swrd` to `swrvalid` is 1 cycle. Back-to-back `swrd` gives one `swrvalid` per cycle.
- The sweep counter is ADDR_W+1 bits wide so the terminal value does not wrap.

## Structure
- Shared package `regfile_pkg` holds:
  - the state encoding constants `RF_INIT` and `RF_RUN`
  - the default `DATA_W` and `ADDR_W`
- Sub-module `rf_bypass_mux` (one instance per read port) is natural. It takes the raw array word, both write-port triples, `BYPASS` and `ready`, and produces `rNdata`, including the zero-register and INIT masking.
- The array is a single `reg [DATA_W-1:0] DFF[0:NREGS-1]` written in one clocked block. The write order is sweep, then pipeline port, then software port, so the last assignment implements the priority.

## Test plan
1. Reset and sweep:
   - Stimulus: release `rst_n`; assert `wena` with `waddr=3`, `wdata=7` during the sweep.
   - Required: `ready` rises exactly 32 edges after release; `r0addr=3` reads 0 (the sweep write wins and the pipeline write is ignored).
2. Basic write/read with `BYPASS=0`:
   - Stimulus: write `5` -> 0xDEAD.
   - Required: `r1data` = 0xDEAD on the next cycle, not in the write cycle.
   - Stimulus: write `0` -> 0xFFFF.
   - Required: address 0 still reads 0.
3. Write collision:
   - Stimulus: `wena` with `waddr=9`, `wdata=1`, and `swena` with `swaddr=9`, `swdata=2`, in the same cycle.
   - Required: `DFF[9]` = 2.
   - Stimulus: same cycle with `waddr=9` and `swaddr=10`.
   - Required: both writes land.
4. Bypass with `BYPASS=1`:
   - Stimulus: `r0addr=4` and `wena` with `waddr=4`, `wdata=0x55`.
   - Required: `r0data` = 0x55 in the same cycle.
   - Stimulus: add `swena` with `swaddr=4`, `swdata=0x66`.
   - Required: `r0data` = 0x66.
5. Software read:
   - Stimulus: `DFF[12]` = 12; `swrd` and `swena` both high with `swaddr=12`, `swdata=99`.
   - Required: `swrvalid` pulses the next cycle with `swrdata` = 12; a second `swrd` then returns 99.
6. Reset mid-operation:
   - Stimulus: assert `rst_n` low in RUN while `swrvalid` is high.
   - Required: `ready` and `swrvalid` drop to 0 asynchronously; after release, a full 32-cycle sweep runs and all registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: FSM encoding and default geometry.
package regfile_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/regfile_mp_rf_bypass_mux.sv
// Read-port output stage: masks reads in INIT and for register 0, optionally forwards write data.
module rf_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wena,
  input  logic [ADDR_W-1:0] swaddr,
  input  logic [DATA_W-1:0] swdata,
  input  logic              swena,
  input  logic              ready,
  output logic [DATA_W-1:0] rdata
);
  localparam logic BYP_EN = (BYPASS != 0);

  // Forwarding priority mirrors the array write priority: software port over pipeline port.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    if (!ready || (raddr == {ADDR_W{1'b0}})) begin
      rdata = {DATA_W{1'b0}};
    end else if (BYP_EN && swena && (swaddr == raddr)) begin
      rdata = swdata;
    end else if (BYP_EN && wena && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      rdata = raw;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, pipeline and software write ports,
// registered software read port, and a zeroing sweep after every reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic [ADDR_W-1:0] r0addr,
  output logic [DATA_W-1:0] r0data,
  input  logic [ADDR_W-1:0] r1addr,
  output logic [DATA_W-1:0] r1data,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wena,
  input  logic [ADDR_W-1:0] swaddr,
  input  logic [DATA_W-1:0] swdata,
  input  logic              swena,
  input  logic              swrd,
  output logic [DATA_W-1:0] swrdata,
  output logic              swrvalid
);
  localparam int              NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(NREGS - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              swrvalid_q, swrvalid_d;
  logic [DATA_W-1:0] swrdata_q, swrdata_d;
  logic [DATA_W-1:0] dff [0:NREGS-1];

  // Next-state logic: sweep counter in INIT, software read capture (old contents) in RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    swrvalid_d = 1'b0;
    swrdata_d  = swrdata_q;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = RF_INIT;
          ready_d = 1'b0;
        end
      end
      RF_RUN: begin
        ready_d = 1'b1;
        if (swrd) begin
          swrvalid_d = 1'b1;
          swrdata_d  = dff[swaddr];
        end else begin
          swrvalid_d = 1'b0;
          swrdata_d  = swrdata_q;
        end
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = {(ADDR_W + 1){1'b0}};
        ready_d = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RF_INIT;
      cnt_q      <= {(ADDR_W + 1){1'b0}};
      ready_q    <= 1'b0;
      swrvalid_q <= 1'b0;
      swrdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      swrvalid_q <= swrvalid_d;
      swrdata_q  <= swrdata_d;
    end
  end

  // Array storage: sweep, then pipeline, then software write; the last assignment wins.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      dff[cnt_q[ADDR_W-1:0]] <= {DATA_W{1'b0}};
    end else begin
      if (wena && (waddr != {ADDR_W{1'b0}})) begin
        dff[waddr] <= wdata;
      end
      if (swena && (swaddr != {ADDR_W{1'b0}})) begin
        dff[swaddr] <= swdata;
      end
    end
  end

  rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd0 (
    .raw(dff[r0addr]), .raddr(r0addr), .waddr(waddr), .wdata(wdata), .wena(wena),
    .swaddr(swaddr), .swdata(swdata), .swena(swena), .ready(ready_q), .rdata(r0data)
  );

  rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
    .raw(dff[r1addr]), .raddr(r1addr), .waddr(waddr), .wdata(wdata), .wena(wena),
    .swaddr(swaddr), .swdata(swdata), .swena(swena), .ready(ready_q), .rdata(r1data)
  );

  assign ready    = ready_q;
  assign swrvalid = swrvalid_q;
  assign swrdata  = swrdata_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one instance without bypass (_a) and one with bypass (_b) share stimulus.
module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] r0addr, r1addr, waddr, swaddr;
  logic [DW-1:0] wdata, swdata;
  logic          wena, swena, swrd;
  logic          ready_a, ready_b, swrvalid_a, swrvalid_b;
  logic [DW-1:0] r0data_a, r0data_b, r1data_a, r1data_b, swrdata_a, swrdata_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [NR];
  bit            ready_m;
  bit            swrvalid_m;
  logic [DW-1:0] swrdata_m;
  int            sweep_edges;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ready(ready_a),
    .r0addr(r0addr), .r0data(r0data_a), .r1addr(r1addr), .r1data(r1data_a),
    .waddr(waddr), .wdata(wdata), .wena(wena),
    .swaddr(swaddr), .swdata(swdata), .swena(swena), .swrd(swrd),
    .swrdata(swrdata_a), .swrvalid(swrvalid_a)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b),
    .r0addr(r0addr), .r0data(r0data_b), .r1addr(r1addr), .r1data(r1data_b),
    .waddr(waddr), .wdata(wdata), .wena(wena),
    .swaddr(swaddr), .swdata(swdata), .swena(swena), .swrd(swrd),
    .swrdata(swrdata_b), .swrvalid(swrvalid_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (!ready_m || a == 0) return '0;
    if (byp && swena && swaddr == a) return swdata;
    if (byp && wena && waddr == a) return wdata;
    return mdl[a];
  endfunction

  // Advance one clock edge and apply to the model what that edge does.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      ready_m = 0; swrvalid_m = 0; swrdata_m = '0; sweep_edges = 0;
    end else if (!ready_m) begin
      sweep_edges++;
      swrvalid_m = 0;
      if (sweep_edges == NR) begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        ready_m = 1;
      end
    end else begin
      swrvalid_m = swrd;
      if (swrd) swrdata_m = mdl[swaddr];
      if (wena && waddr != 0) mdl[waddr] = wdata;
      if (swena && swaddr != 0) mdl[swaddr] = swdata;
    end
    #1;
  endtask

  task automatic idle();
    r0addr = '0; r1addr = '0; waddr = '0; swaddr = '0;
    wdata = '0; swdata = '0; wena = 0; swena = 0; swrd = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    ready_m = 0; swrvalid_m = 0; swrdata_m = '0; sweep_edges = 0;
    #3;
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0 || swrvalid_a !== 1'b0 || swrdata_a !== '0) begin
      errors++;
      $display("FAIL reset_values ready=%b/%b swrvalid=%b swrdata=%h, required 0/0/0/0",
               ready_a, ready_b, swrvalid_a, swrdata_a);
    end
    tick(); tick();
    rst_n = 1;
    wena = 1; waddr = 5'd3; wdata = 64'd7; r0addr = 5'd3;
    for (int i = 1; i <= NR; i++) begin
      tick();
      checks++;
      if (ready_a !== (i == NR) || ready_b !== (i == NR)) begin
        errors++;
        $display("FAIL sweep_ready edge %0d ready=%b/%b required %b", i, ready_a, ready_b, i == NR);
      end
    end
    wena = 0;
    #2;
    checks++;
    if (r0data_a !== 64'd0 || r0data_b !== 64'd0) begin
      errors++;
      $display("FAIL sweep_wins r0data=%h/%h required 0", r0data_a, r0data_b);
    end
  endtask

  task automatic test_basic();
    idle();
    wena = 1; waddr = 5'd5; wdata = 64'hDEAD; r1addr = 5'd5;
    #2;
    checks++;
    if (r1data_a !== 64'd0 || r1data_b !== 64'hDEAD) begin
      errors++;
      $display("FAIL basic_write_cycle r1data=%h/%h required 0/dead", r1data_a, r1data_b);
    end
    tick();
    wena = 0;
    #2;
    checks++;
    if (r1data_a !== 64'hDEAD || r1data_b !== 64'hDEAD) begin
      errors++;
      $display("FAIL basic_next_cycle r1data=%h/%h required dead", r1data_a, r1data_b);
    end
    wena = 1; waddr = 5'd0; wdata = 64'hFFFF; r0addr = 5'd0;
    #2;
    checks++;
    if (r0data_b !== 64'd0) begin
      errors++;
      $display("FAIL zero_reg_bypass r0data=%h required 0", r0data_b);
    end
    tick();
    wena = 0;
    #2;
    checks++;
    if (r0data_a !== 64'd0 || r0data_b !== 64'd0) begin
      errors++;
      $display("FAIL zero_reg r0data=%h/%h required 0", r0data_a, r0data_b);
    end
  endtask

  task automatic test_collision();
    idle();
    wena = 1; waddr = 5'd9; wdata = 64'd1; swena = 1; swaddr = 5'd9; swdata = 64'd2;
    tick();
    idle(); r0addr = 5'd9;
    #2;
    checks++;
    if (r0data_a !== 64'd2 || r0data_b !== 64'd2) begin
      errors++;
      $display("FAIL collision_same r0data=%h/%h required 2", r0data_a, r0data_b);
    end
    wena = 1; waddr = 5'd9; wdata = 64'd3; swena = 1; swaddr = 5'd10; swdata = 64'd4;
    tick();
    idle(); r0addr = 5'd9; r1addr = 5'd10;
    #2;
    checks++;
    if (r0data_a !== 64'd3 || r1data_a !== 64'd4 || r0data_b !== 64'd3 || r1data_b !== 64'd4) begin
      errors++;
      $display("FAIL collision_diff r0=%h/%h r1=%h/%h required 3,4",
               r0data_a, r0data_b, r1data_a, r1data_b);
    end
  endtask

  task automatic test_bypass();
    idle();
    r0addr = 5'd4; wena = 1; waddr = 5'd4; wdata = 64'h55;
    #2;
    checks++;
    if (r0data_b !== 64'h55 || r0data_a !== 64'd0) begin
      errors++;
      $display("FAIL bypass_wdata r0data=%h/%h required 0/55", r0data_a, r0data_b);
    end
    swena = 1; swaddr = 5'd4; swdata = 64'h66;
    #2;
    checks++;
    if (r0data_b !== 64'h66) begin
      errors++;
      $display("FAIL bypass_swdata r0data=%h required 66", r0data_b);
    end
    tick();
    idle(); r0addr = 5'd4;
    #2;
    checks++;
    if (r0data_a !== 64'h66 || r0data_b !== 64'h66) begin
      errors++;
      $display("FAIL bypass_stored r0data=%h/%h required 66", r0data_a, r0data_b);
    end
  endtask

  task automatic test_swread();
    idle();
    swena = 1; swaddr = 5'd12; swdata = 64'd12;
    tick();
    swdata = 64'd99; swrd = 1;
    tick();
    swena = 0;
    #2;
    checks++;
    if (swrvalid_a !== 1'b1 || swrdata_a !== 64'd12 || swrvalid_b !== 1'b1 || swrdata_b !== 64'd12) begin
      errors++;
      $display("FAIL swread_rbw valid=%b/%b data=%h/%h required 1,12",
               swrvalid_a, swrvalid_b, swrdata_a, swrdata_b);
    end
    tick();
    swrd = 0;
    #2;
    checks++;
    if (swrvalid_a !== 1'b1 || swrdata_a !== 64'd99 || swrdata_b !== 64'd99) begin
      errors++;
      $display("FAIL swread_second valid=%b data=%h/%h required 1,99", swrvalid_a, swrdata_a, swrdata_b);
    end
    tick();
    #2;
    checks++;
    if (swrvalid_a !== 1'b0 || swrvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL swread_pulse valid=%b/%b required 0", swrvalid_a, swrvalid_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wena   = 1'($urandom_range(0, 1));
      swena  = 1'($urandom_range(0, 1));
      swrd   = 1'($urandom_range(0, 1));
      waddr  = AW'($urandom_range(0, NR - 1));
      swaddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
      r0addr = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
      r1addr = ($urandom_range(0, 2) == 0) ? swaddr : AW'($urandom_range(0, NR - 1));
      wdata  = {$urandom, $urandom};
      swdata = {$urandom, $urandom};
      #2;
      checks++;
      if (r0data_a !== exp_read(r0addr, 0) || r0data_b !== exp_read(r0addr, 1)) begin
        errors++;
        $display("FAIL rand_r0 cycle %0d addr %0d got %h/%h required %h/%h", c, r0addr,
                 r0data_a, r0data_b, exp_read(r0addr, 0), exp_read(r0addr, 1));
      end
      checks++;
      if (r1data_a !== exp_read(r1addr, 0) || r1data_b !== exp_read(r1addr, 1)) begin
        errors++;
        $display("FAIL rand_r1 cycle %0d addr %0d got %h/%h required %h/%h", c, r1addr,
                 r1data_a, r1data_b, exp_read(r1addr, 0), exp_read(r1addr, 1));
      end
      checks++;
      if (swrvalid_a !== swrvalid_m || swrvalid_b !== swrvalid_m ||
          swrdata_a !== swrdata_m || swrdata_b !== swrdata_m) begin
        errors++;
        $display("FAIL rand_swr cycle %0d valid=%b/%b data=%h/%h required %b,%h", c,
                 swrvalid_a, swrvalid_b, swrdata_a, swrdata_b, swrvalid_m, swrdata_m);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    swrd = 1; swaddr = 5'd7;
    tick();
    #2;
    checks++;
    if (swrvalid_a !== 1'b1 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre swrvalid=%b ready=%b required 1/1", swrvalid_a, ready_a);
    end
    rst_n = 0;
    #1;
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0 || swrvalid_a !== 1'b0 || swrvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async ready=%b/%b swrvalid=%b/%b required 0",
               ready_a, ready_b, swrvalid_a, swrvalid_b);
    end
    tick(); tick();
    rst_n = 1;
    idle();
    for (int i = 1; i <= NR; i++) begin
      tick();
      checks++;
      if (ready_a !== (i == NR) || ready_b !== (i == NR)) begin
        errors++;
        $display("FAIL midreset_sweep edge %0d ready=%b/%b required %b", i, ready_a, ready_b, i == NR);
      end
    end
    for (int a = 0; a < NR; a++) begin
      r0addr = AW'(a); r1addr = AW'(a);
      #2;
      checks++;
      if (r0data_a !== 64'd0 || r1data_a !== 64'd0 || r0data_b !== 64'd0 || r1data_b !== 64'd0) begin
        errors++;
        $display("FAIL midreset_zero reg %0d got %h/%h/%h/%h required 0",
                 a, r0data_a, r1data_a, r0data_b, r1data_b);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_swread();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
